// File: rtl/audio_pkg.sv
// Shared audio types for the generators, the decimator and the DAC.
package audio_pkg;
  localparam int DIV_48KHZ = 259;
  typedef logic [7:0] audio_sample_t;
endpackage

// File: rtl/audio_sample_decimator_if.sv
// Decimated sample stream with valid/ready handshake.
interface audio_sample_decimator_if;
  import audio_pkg::*;
  logic          m_valid_o;
  audio_sample_t m_data_o;
  logic          m_ready_i;

  modport master (output m_valid_o, output m_data_o, input m_ready_i);
  modport slave  (input m_valid_o, input m_data_o, output m_ready_i);
endinterface

// File: rtl/audio_sync_fifo.sv
// First-word fall-through sync FIFO; head is valid whenever not empty.
// Push into a full FIFO succeeds only if the head is popped in the same cycle.
module audio_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      // When full, wr_ptr == rd_ptr: the old head is read combinationally this cycle.
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      level <= level + 1'b1;
      else if (do_pop && !do_push) level <= level - 1'b1;
    end
  end
endmodule

// File: rtl/audio_sample_decimator.sv
// Box-filters the generator stream over the tail of each period and queues
// one averaged sample per period; drops (sticky overflow) when the FIFO is full.
module audio_sample_decimator
  import audio_pkg::*;
#(
  parameter int DIV      = DIV_48KHZ,
  parameter int AVG_LOG2 = 8,
  parameter int DEPTH    = 4
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      enable_i,
  input  audio_sample_t             sample_data_i,
  audio_sample_decimator_if.master  m_if,
  output logic [$clog2(DEPTH):0]    level_o,
  output logic                      overflow_o,
  input  logic                      clear_ovf_i
);
  localparam int CW        = $clog2(DIV + 1);
  localparam int AW        = 8 + AVG_LOG2;
  localparam int WIN_START = DIV + 1 - (1 << AVG_LOG2);

  logic [CW-1:0] cnt;
  logic [AW-1:0] acc;
  logic [AW-1:0] acc_sum;
  logic          win;
  logic          period_end;
  logic          pop;
  logic          full;
  logic          empty;
  logic          drop;
  audio_sample_t avg;
  audio_sample_t head;

  assign period_end = enable_i & (cnt == CW'(DIV));
  assign win        = enable_i & (cnt >= CW'(WIN_START));
  assign acc_sum    = acc + AW'(sample_data_i);
  assign avg        = audio_sample_t'(acc_sum >> AVG_LOG2);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= '0;
      acc <= '0;
    end else if (!enable_i || period_end) begin
      cnt <= '0;
      acc <= '0;
    end else begin
      cnt <= cnt + 1'b1;
      if (win) acc <= acc_sum;
    end
  end

  assign pop  = m_if.m_valid_o & m_if.m_ready_i;
  assign drop = period_end & full & ~pop;

  audio_sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .push      (period_end),
    .push_data (avg),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .level     (level_o)
  );

  assign m_if.m_valid_o = ~empty;
  assign m_if.m_data_o  = head;

  // A drop in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)            overflow_o <= 1'b0;
    else if (drop)        overflow_o <= 1'b1;
    else if (clear_ovf_i) overflow_o <= 1'b0;
  end
endmodule

// File: doc/audio_sample_decimator.md
Name: audio_sample_decimator

Overview:
- Downstream stage of the noise/tone generators.
- Consumes the free-running 8-bit `sample_data_o` stream, which changes at 12.5 MHz clock rate.
- Box-filters (averages) it over the tail of each 48 kHz sample period.
- Pushes one decimated sample per period into a small FIFO with a valid/ready output, feeding the PWM DAC / capture logic.

Parameters:
- DIV, 259, period divider; one sample per DIV+1 clocks (12.5 MHz / 260 ≈ 48.08 kHz).
- AVG_LOG2, 8, averaging window = 2^AVG_LOG2 clocks at the end of each period; requires 2^AVG_LOG2 <= DIV+1.
- DEPTH, 4, FIFO entries; power of 2, >= 2.

Ports:
- clk  in  1  system clock, 12.5 MHz.
- rstn  in  1  asynchronous, active-low reset.
- enable_i  in  1  run decimator; low holds period counter and accumulator at 0.
- sample_data_i  in  8  unsigned generator sample, sampled every clock.
- m_valid_o  out  1  FIFO non-empty.
- m_data_o  out  8  FIFO head sample.
- m_ready_i  in  1  consumer accepts head when m_valid_o & m_ready_i.
- level_o  out  $clog2(DEPTH)+1  FIFO occupancy.
- overflow_o  out  1  sticky: a decimated sample was dropped.
- clear_ovf_i  in  1  clears overflow_o.

Behaviour:
- Reset (async, rstn=0) clears:
  - cnt = 0, acc = 0, FIFO pointers = 0, FIFO storage = 0.
  - m_valid_o = 0, m_data_o = 0, level_o = 0, overflow_o = 0.
- Period counter cnt, width $clog2(DIV+1):
  - When enable_i=1: cnt = (cnt==DIV) ? 0 : cnt+1 each clock.
  - When enable_i=0: cnt <= 0, acc <= 0, no push. The FIFO still drains normally.
- Window:
  - win = enable_i & (cnt >= DIV+1-2^AVG_LOG2).
  - acc width 8+AVG_LOG2; it cannot overflow.
  - In window, cnt != DIV: acc <= acc + sample_data_i.
- End of period (enable_i & cnt==DIV):
  - avg = (acc + sample_data_i) >> AVG_LOG2, truncating.
  - Push request with avg; acc <= 0.
- Latency:
  - Edges 1..DIV+1 after enable rises see cnt = 0..DIV.
  - Push occurs on edge DIV+1. m_valid_o is high after that edge (first sample), then every DIV+1 clocks.
- FIFO, registered, first-word fall-through:
  - m_data_o = mem[rd_ptr]; m_valid_o = (level != 0).
  - pop = m_valid_o & m_ready_i; it advances rd_ptr.
  - Push is accepted if level < DEPTH, or if pop occurs in the same cycle (full with simultaneous pop: both happen, level unchanged).
  - Push while full without pop: sample dropped, FIFO unchanged, overflow_o <= 1.
  - Push and pop when level==1: level stays 1, new sample becomes head next cycle.
  - Pop when empty: impossible by definition (pop requires m_valid_o).
  - Pointers wrap modulo DEPTH.
- overflow_o:
  - Set by a drop, cleared by clear_ovf_i.
  - Drop and clear in the same cycle: set wins, overflow_o = 1.
- enable_i falling mid-period: partial accumulation is discarded, no push. On re-enable a full fresh period starts at cnt=0.
- Reset mid-operation: all state returns to reset values immediately (async), including FIFO contents.

Decomposition:
- audio_pkg:
  - localparam DIV_48KHZ = 259.
  - typedef logic [7:0] audio_sample_t.
  - Shared with the generators and DAC.
- Sub-module audio_sync_fifo: parameters WIDTH and DEPTH, ports push/pop/full/empty/level.
- Decimator top: counter, window decode, accumulator, overflow flag.

Test Plan:
- Reset: hold rstn=0 with random inputs -> m_valid_o=0, m_data_o=0x00, level_o=0, overflow_o=0. Release and keep enable_i=0 for 1000 clocks -> m_valid_o stays 0.
- Constant input, defaults: sample_data_i=0xA5, enable_i=1, m_ready_i=1.
  - First m_valid_o after edge 260.
  - Every accepted m_data_o=0xA5, one every 260 clocks.
- Alternating 0x00/0xFF each clock, AVG_LOG2=8 -> output 0x7F (32640>>8).
- Samples outside the window: input 0x10 during cnt<4, 0x40 otherwise -> output 0x40.
- Overflow, DEPTH=4, 0x11,0x22,… per period:
  - m_ready_i=0 for 5 periods -> level 1,2,3,4,4; overflow_o=1 after the 5th push.
  - Then m_ready_i=1 -> 0x11,0x22,0x33,0x44 in order.
  - clear_ovf_i coinciding with a drop -> overflow_o stays 1.
- Full with simultaneous pop at push edge -> push accepted, level stays 4, no overflow.
- Enable off at cnt=100 for 50 clocks, then on:
  - Next push comes 260 clocks after re-enable.
  - The average contains only post-enable samples.
- rstn pulse while level=3 -> level_o=0 and m_valid_o=0 immediately.
